// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_scan display stage: segment glyphs, digit count
// and the state type of the optional decimal converter.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low {dp,g,f,e,d,c,b,a}; element index is the hex digit value.
    localparam logic [15:0][7:0] SEG_GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } conv_state_e;

    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        return SEG_GLYPH[nib];
    endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Double-dabble binary-to-BCD converter used by seg7_scan when SEG7_DECIMAL_EN is
// defined; strobe-to-bcd_valid latency is 17 cycles, strobes while busy are held.
`ifdef SEG7_DECIMAL_EN
module seg7_bin2bcd
    import seg7_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] bin_in,
    input  logic        bin_valid,
    output logic [15:0] bcd_out,
    output logic        ovf_out,
    output logic        bcd_valid
);

    conv_state_e state_q;
    logic [15:0] shift_q;
    logic [19:0] bcd_q;
    logic [3:0]  iter_q;
    logic        pend_valid_q;
    logic [15:0] pend_data_q;
    logic [15:0] bcd_out_q;
    logic        ovf_q;
    logic        bcd_valid_q;

    // One add-3-then-shift step over five BCD nibbles and the remaining binary bits.
    function automatic logic [35:0] dabble_step(input logic [19:0] bcd, input logic [15:0] bin);
        logic [19:0] adj;
        for (int i = 0; i < 5; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        return {adj, bin} << 1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bcd_q        <= '0;
            iter_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            bcd_out_q    <= '0;
            ovf_q        <= 1'b0;
            bcd_valid_q  <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            if (bin_valid && state_q != ST_IDLE) begin
                pend_valid_q <= 1'b1;
                pend_data_q  <= bin_in;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bin_valid || pend_valid_q) begin
                        shift_q      <= bin_valid ? bin_in : pend_data_q;
                        bcd_q        <= '0;
                        iter_q       <= '0;
                        pend_valid_q <= 1'b0;
                        state_q      <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {bcd_q, shift_q} <= dabble_step(bcd_q, shift_q);
                    iter_q           <= iter_q + 4'd1;
                    if (iter_q == 4'd15) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_out_q   <= bcd_q[15:0];
                    ovf_q       <= |bcd_q[19:16];
                    bcd_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bcd_out   = bcd_out_q;
    assign ovf_out   = ovf_q;
    assign bcd_valid = bcd_valid_q;

endmodule
`endif

// File: rtl/seg7_scan.sv
// 4-digit multiplexed common-anode 7-segment driver with halt blink on digit 0 dp.
// Define SEG7_DECIMAL_EN to show the value as unsigned decimal instead of hex.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 20000,
    parameter int unsigned BLINK_SCANS = 2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] out_data,
    input  logic        out_valid,
    input  logic        halted,
    output logic [7:0]  seg_n,
    output logic [3:0]  dig_sel_n
);

    localparam int unsigned PW = $clog2(SCAN_DIV + 1);
    localparam int unsigned BW = $clog2(BLINK_SCANS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_SCANS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic [15:0]   display_q, display_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [7:0]    seg_n_q, seg_n_d;
    logic [3:0]    dig_sel_n_q, dig_sel_n_d;

    logic          scan_tick;
    logic [3:0]    cur_nibble;
    logic [7:0]    cur_glyph;
    logic          dp_on;

    assign scan_tick  = (presc_q == PRESC_MAX);
    assign cur_nibble = display_q[{digit_idx_q, 2'b00} +: 4];
    assign dp_on      = halted && blink_q && (digit_idx_q == 2'd0);

`ifdef SEG7_DECIMAL_EN
    logic        ovf_q, ovf_d;
    logic [15:0] conv_bcd;
    logic        conv_ovf;
    logic        conv_valid;

    seg7_bin2bcd u_bin2bcd (
        .clock     (clock),
        .reset     (reset),
        .bin_in    (out_data),
        .bin_valid (out_valid),
        .bcd_out   (conv_bcd),
        .ovf_out   (conv_ovf),
        .bcd_valid (conv_valid)
    );

    always_comb begin
        display_d = conv_valid ? conv_bcd : display_q;
        ovf_d     = conv_valid ? conv_ovf : ovf_q;
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        if (ovf_q) begin
            cur_glyph = SEG_DASH;
        end else if (digit_idx_q != 2'd0 && (display_q >> {digit_idx_q, 2'b00}) == 16'h0) begin
            cur_glyph = SEG_BLANK;
        end else begin
            cur_glyph = hex_glyph(cur_nibble);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`else
    assign display_d = out_valid ? out_data : display_q;
    assign cur_glyph = hex_glyph(cur_nibble);
`endif

    always_comb begin
        // NOTE: every _d takes its hold value first so no branch can leave it unassigned (no latch).
        presc_d     = scan_tick ? '0 : presc_q + PW'(1);
        digit_idx_d = digit_idx_q;
        seg_n_d     = seg_n_q;
        dig_sel_n_d = dig_sel_n_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;

        // Select and segments change on the same edge so a digit never shows its neighbour's glyph.
        if (scan_tick) begin
            digit_idx_d = digit_idx_q + 2'd1;
            seg_n_d     = cur_glyph & {~dp_on, 7'h7F};
            dig_sel_n_d = ~(4'b0001 << digit_idx_q);
        end

        if (!halted) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (scan_tick) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            digit_idx_q <= '0;
            display_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            seg_n_q     <= SEG_BLANK;
            dig_sel_n_q <= 4'b1111;
        end else begin
            presc_q     <= presc_d;
            digit_idx_q <= digit_idx_d;
            display_q   <= display_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            seg_n_q     <= seg_n_d;
            dig_sel_n_q <= dig_sel_n_d;
        end
    end

    assign seg_n     = seg_n_q;
    assign dig_sel_n = dig_sel_n_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (SCAN_DIV=4, BLINK_SCANS=2); covers the hex path by
// default and the decimal path when SEG7_DECIMAL_EN is defined.
module tb_seg7_scan;

    localparam int SCAN_DIV    = 4;
    localparam int BLINK_SCANS = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] out_data;
    logic        out_valid;
    logic        halted;
    logic [7:0]  seg_n;
    logic [3:0]  dig_sel_n;

    seg7_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_SCANS (BLINK_SCANS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .seg_n     (seg_n),
        .dig_sel_n (dig_sel_n)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [3:0] dig;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int edge_no;
    int m_idx;
    int m_val;
    int m_blink_cnt;
    bit m_blink;
    bit conv_busy;
    int conv_start;
    int conv_val;
    bit pend_v;
    int pend_val;

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0:       return 8'hC0;
            1:       return 8'hF9;
            2:       return 8'hA4;
            3:       return 8'hB0;
            4:       return 8'h99;
            5:       return 8'h92;
            6:       return 8'h82;
            7:       return 8'hF8;
            8:       return 8'h80;
            9:       return 8'h90;
            10:      return 8'h88;
            11:      return 8'h83;
            12:      return 8'hC6;
            13:      return 8'hA1;
            14:      return 8'h86;
            15:      return 8'h8E;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int idx, input int val);
`ifdef SEG7_DECIMAL_EN
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (val > 9999) return 8'hBF;
        if (idx != 0 && val < p) return 8'hFF;
        return glyph((val / p) % 10);
`else
        return glyph((val >> (4 * idx)) & 15);
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic reset_model();
        m_idx       = 0;
        m_val       = 0;
        m_blink_cnt = 0;
        m_blink     = 0;
        conv_busy   = 0;
        pend_v      = 0;
    endtask

    task automatic conv_begin(input int v);
        conv_busy  = 1;
        conv_start = edge_no;
        conv_val   = v;
    endtask

    // Advance the model across one rising edge, using the inputs that were present at it.
    task automatic model_edge(input bit stb, input int data, input bit tick);
        edge_no++;
`ifdef SEG7_DECIMAL_EN
        if (conv_busy && edge_no == conv_start + 18) begin
            m_val     = conv_val;
            conv_busy = 0;
        end
        if (stb) begin
            if (conv_busy) begin
                pend_v   = 1;
                pend_val = data;
            end else begin
                conv_begin(data);
                pend_v = 0;
            end
        end else if (!conv_busy && pend_v) begin
            conv_begin(pend_val);
            pend_v = 0;
        end
`else
        if (stb) m_val = data;
`endif
        if (!halted) begin
            m_blink_cnt = 0;
            m_blink     = 0;
        end else if (tick) begin
            if (m_blink_cnt == BLINK_SCANS - 1) begin
                m_blink_cnt = 0;
                m_blink     = !m_blink;
            end else begin
                m_blink_cnt++;
            end
        end
        if (tick) m_idx = (m_idx + 1) % 4;
    endtask

    // One digit slot: SCAN_DIV cycles starting right after a scan tick, optional strobes
    // on cycles stb_cyc.., expected pair pushed before the tick edge and checked after it.
    task automatic run_slot(input string tag, input int stb_cyc, input int n_stb,
                            input int d0, input int d1, input bit pre_blank);
        exp_t e;
        for (int c = 0; c < SCAN_DIV; c++) begin
            bit stb;
            int d;
            stb = (n_stb > 0) && (c >= stb_cyc) && (c < stb_cyc + n_stb);
            d   = (c == stb_cyc) ? d0 : d1;
            if (c == SCAN_DIV - 1) begin
                if (pre_blank) begin
                    check({tag, "/pre_tick_dig_sel_n"}, {4'h0, dig_sel_n}, 8'h0F);
                    check({tag, "/pre_tick_seg_n"}, seg_n, 8'hFF);
                end
                e.tag = tag;
                e.dig = ~(4'b0001 << m_idx);
                e.seg = exp_seg(m_idx, m_val);
                if (halted && m_blink && m_idx == 0) e.seg[7] = 1'b0;
                exp_q.push_back(e);
            end
            out_valid = stb;
            out_data  = stb ? d[15:0] : 16'h0000;
            @(negedge clock);
            model_edge(stb, d, c == SCAN_DIV - 1);
            if (c == SCAN_DIV - 1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL %s: scoreboard empty at scan tick", tag);
                end else begin
                    e = exp_q.pop_front();
                    check({e.tag, "/dig_sel_n"}, {4'h0, dig_sel_n}, {4'h0, e.dig});
                    check({e.tag, "/seg_n"}, seg_n, e.seg);
                end
            end
        end
        out_valid = 1'b0;
        out_data  = 16'h0000;
    endtask

    initial begin
        reset     = 1'b0;
        out_valid = 1'b0;
        out_data  = 16'h0000;
        halted    = 1'b0;
        edge_no   = 0;
        reset_model();

        repeat (3) @(negedge clock);
        check("reset/seg_n", seg_n, 8'hFF);
        check("reset/dig_sel_n", {4'h0, dig_sel_n}, 8'h0F);

        reset = 1'b1;
        run_slot("first_tick", 0, 0, 0, 0, 1'b1);
        for (int i = 1; i < 4; i++) run_slot("zero_frame", 0, 0, 0, 0, 1'b0);

`ifndef SEG7_DECIMAL_EN
        run_slot("coincident_tick_old", SCAN_DIV - 1, 1, 16'h0001, 0, 1'b0);
        for (int i = 0; i < 3; i++) run_slot("after_coincident", 0, 0, 0, 0, 1'b0);
        run_slot("coincident_new_digit0", 0, 0, 0, 0, 1'b0);
        run_slot("back_to_back_last_wins", 0, 2, 16'hFFFF, 16'h12AF, 1'b0);
        for (int i = 0; i < 4; i++) run_slot("frame_12af", 0, 0, 0, 0, 1'b0);
`else
        run_slot("dec_1234_strobe", 1, 1, 1234, 0, 1'b0);
        for (int i = 0; i < 8; i++) run_slot("dec_1234", 0, 0, 0, 0, 1'b0);
        run_slot("dec_ovf_strobe", 0, 1, 10000, 0, 1'b0);
        for (int i = 0; i < 8; i++) run_slot("dec_ovf", 0, 0, 0, 0, 1'b0);
        run_slot("dec_7_strobe", 0, 1, 7, 0, 1'b0);
        run_slot("dec_42_pending", 0, 1, 42, 0, 1'b0);
        for (int i = 0; i < 12; i++) run_slot("dec_42", 0, 0, 0, 0, 1'b0);
`endif

        for (int i = 0; i < 4 && m_idx != 2; i++) run_slot("blink_align", 0, 0, 0, 0, 1'b0);
        halted = 1'b1;
        for (int i = 0; i < 8; i++) run_slot("halt_blink", 0, 0, 0, 0, 1'b0);
        halted = 1'b0;
        for (int i = 0; i < 4; i++) run_slot("halt_cleared", 0, 0, 0, 0, 1'b0);

        @(negedge clock);
        model_edge(1'b0, 0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midscan_reset/seg_n", seg_n, 8'hFF);
        check("midscan_reset/dig_sel_n", {4'h0, dig_sel_n}, 8'h0F);
        @(negedge clock);
        reset_model();
        reset = 1'b1;
        run_slot("post_reset_first_tick", 0, 0, 0, 0, 1'b1);
        for (int i = 1; i < 4; i++) run_slot("post_reset_frame", 0, 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream display stage for the simple1 system: consumes the 16-bit value the core emits on its output port and drives a 4-digit multiplexed common-anode 7-segment display.
- Latches each output strobe, time-multiplexes the digits at a fixed refresh rate and shows core halt status on the decimal point.
- Runs in the core's 80 MHz domain; all inputs are synchronous to it.

Parameters:
- SCAN_DIV, 20000, clock cycles per digit slot (80 MHz / 20000 = 4 kHz slot rate, 1 kHz frame rate).
- BLINK_SCANS, 2000, digit slots per halt-blink half-period (0.5 s at defaults).

Ports:
- clock  in  1  system clock (80 MHz PLL output).
- reset  in  1  asynchronous, active-low reset.
- out_data  in  16  value from the core output instruction.
- out_valid  in  1  single-cycle strobe: out_data is valid.
- halted  in  1  level-high while the core is halted.
- seg_n  out  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
- dig_sel_n  out  4  digit enables, active-low one-hot; bit0 = rightmost (least significant), registered.

Behaviour:
- Reset (reset=0, asynchronous assert):
  - seg_n=8'hFF, dig_sel_n=4'b1111.
  - Display register 0, prescaler 0, digit index 0, blink state 0.
- Release is used synchronously.
- Latch:
  - out_valid=1 at edge N loads out_data into the display register at edge N.
  - out_data is ignored when out_valid=0.
  - Back-to-back strobes: the last one wins.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - The wrap cycle is the scan tick.
  - The first tick after reset release occurs SCAN_DIV cycles later.
- On each scan tick:
  - Digit index advances 0->1->2->3->0.
  - dig_sel_n and seg_n are updated on the same edge, so outputs never show a mismatched digit/segment pair.
  - dig_sel_n stays 4'b1111 until the first tick.
- Hex decode: the digit nibble selects segments 0-F with standard glyphs. Active-low values: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (dp bit 1 = off).
- Simultaneous out_valid and scan tick: the tick decodes the old display register; the new value appears from the following tick.
- Halt blink:
  - A counter of scan ticks toggles blink state every BLINK_SCANS ticks while halted=1.
  - dp is lit (bit7=0) on digit 0 only when halted=1 and blink state=1.
  - halted=0 clears the counter and blink state synchronously; dp off.
- Reset mid-frame blanks all outputs immediately and restarts the scan at digit 0.

Optional Feature:
- Macro SEG7_DECIMAL_EN.
- Defined: display is unsigned decimal.
  - Conversion FSM with states IDLE, CONV, DONE.
  - A strobe in IDLE loads the shift register and enters CONV.
  - CONV runs 16 double-dabble cycles (add 3 to any BCD nibble >=5, then shift).
  - DONE writes the 4 BCD digits to the display register in one cycle, then returns to IDLE. Latency from strobe to display register is 18 cycles.
  - A strobe during CONV/DONE is held in a pending register (last wins). Conversion restarts from IDLE the cycle after DONE.
  - Values >9999 show "----" (seg_n=BF on all digits).
  - Leading zeros are blanked (seg_n=FF) except digit 0.
  - During conversion the previous digits stay displayed.
- Undefined: the FSM is absent; the hex path is as above.

Decomposition:
- Package seg7_pkg:
  - segment glyph constants for 0-F, blank, and dash;
  - digit-count constant 4;
  - FSM state typedef for the decimal converter.
- One sub-module, seg7_bin2bcd: the double-dabble FSM, instantiated only under SEG7_DECIMAL_EN.

Test Plan:
- Reset low mid-scan -> seg_n=FF, dig_sel_n=1111 within the same cycle; after release, first dig_sel_n=1110 exactly SCAN_DIV cycles later (use SCAN_DIV=4 in bench).
- out_valid with out_data=16'h12AF -> over one frame: digits 0..3 show 8E, 88, A4, F9 with dig_sel_n 1110, 1101, 1011, 0111.
- out_valid asserted on a scan-tick cycle with 16'h0001, previous value 0 -> that slot shows C0 for the old value; digit 0 shows F9 at its next slot.
- halted=1, BLINK_SCANS=2 -> digit-0 dp toggles every 2 ticks (seg_n bit7 alternates); halted=0 -> dp off at the next digit-0 slot.
- SEG7_DECIMAL_EN, strobe 16'd1234 -> display register holds BCD 1,2,3,4 after 18 cycles; glyphs F9, A4, B0, 99 on digits 3..0.
- SEG7_DECIMAL_EN:
  - strobe 16'd10000 -> all digits BF;
  - strobe 16'd7 then 16'd42 during CONV -> final display FF, FF, 99, A4 (42, leading zeros blanked).
